// File: rtl/pixel_array_ctrl_pkg.sv
// Shared types and Gray-code helpers for the pixel array sequencer.
package pixel_ctrl_pkg;

  localparam int NUM_PIX_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_RD_GAP,
    S_RD_DRIVE,
    S_RD_OUT,
    S_DONE
  } state_t;

  function automatic logic [31:0] gray_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray_dec(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int k = 30; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

endpackage

// File: rtl/pixel_array_ctrl_gray_counter.sv
// Binary ramp counter with a registered Gray-coded copy.
module gray_counter
  import pixel_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic             EN,
  output logic [CNT_W-1:0] BIN,
  output logic [CNT_W-1:0] GRAY
);

  logic [CNT_W-1:0] nb;

  assign nb = BIN + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (!RESET_N || CLR) begin
      BIN  <= '0;
      GRAY <= '0;
    end else if (EN) begin
      BIN  <= nb;
      GRAY <= CNT_W'(gray_enc(32'(nb)));
    end
  end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Erase/expose/convert/readout sequencer for the four-pixel array.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int NUM_PIX     = NUM_PIX_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int ERASE_CYC   = 5,
  parameter int EXPOSE_CYC  = 255,
  parameter int CONVERT_CYC = 256,
  localparam int IDX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     START,
  output logic                     ERASE,
  output logic                     PIX_RESET,
  output logic                     EXPOSE,
  output logic                     RAMP_EN,
  output logic [NUM_PIX-1:0]       READ,
  output logic                     DATA_OE,
  output logic [CNT_W-1:0]         DATA_OUT,
  input  logic [NUM_PIX*CNT_W-1:0] DATA_IN,
  output logic                     PIX_VALID,
  input  logic                     PIX_READY,
  output logic [CNT_W-1:0]         PIX_DATA,
  output logic [IDX_W-1:0]         PIX_IDX,
  output logic                     BUSY,
  output logic                     FRAME_DONE
);

  localparam logic [15:0] ER_LAST = 16'(ERASE_CYC - 1);
  localparam logic [15:0] EX_LAST = 16'(EXPOSE_CYC - 1);
  localparam logic [CNT_W-1:0] CV_LAST = CNT_W'(CONVERT_CYC - 1);
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(NUM_PIX - 1);

  state_t           state;
  state_t           nxt;
  logic [15:0]      ph;
  logic [CNT_W-1:0] bin;
  logic [CNT_W-1:0] gray;
  logic             conv;

  assign conv     = (state == S_CONVERT);
  assign DATA_OUT = gray;

  gray_counter #(.CNT_W(CNT_W)) u_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CLR     (!conv),
    .EN      (conv),
    .BIN     (bin),
    .GRAY    (gray)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:     if (START) nxt = S_ERASE;
      S_ERASE:    if (ph == ER_LAST) nxt = S_EXPOSE;
      S_EXPOSE:   if (ph == EX_LAST) nxt = S_CONVERT;
      S_CONVERT:  if (bin == CV_LAST) nxt = S_RD_GAP;
      S_RD_GAP:   nxt = S_RD_DRIVE;
      S_RD_DRIVE: if (ph == 16'd1) nxt = S_RD_OUT;
      S_RD_OUT:
        if (PIX_READY)
          nxt = (PIX_IDX == PIX_LAST) ? S_DONE : S_RD_GAP;
      S_DONE:     nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      ph         <= '0;
      ERASE      <= 1'b0;
      PIX_RESET  <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP_EN    <= 1'b0;
      DATA_OE    <= 1'b0;
      READ       <= '0;
      PIX_VALID  <= 1'b0;
      PIX_DATA   <= '0;
      PIX_IDX    <= '0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= nxt;
      ph         <= (nxt != state) ? '0 : ph + 16'd1;
      ERASE      <= (nxt == S_ERASE);
      PIX_RESET  <= (nxt == S_ERASE);
      EXPOSE     <= (nxt == S_EXPOSE);
      RAMP_EN    <= (nxt == S_CONVERT);
      DATA_OE    <= (nxt == S_CONVERT);
      READ       <= (nxt == S_RD_DRIVE) ? NUM_PIX'(1) << PIX_IDX : '0;
      PIX_VALID  <= (nxt == S_RD_OUT);
      BUSY       <= (nxt != S_IDLE);
      FRAME_DONE <= (nxt == S_DONE);
      if (conv && nxt != S_CONVERT)
        PIX_IDX <= '0;
      if (state == S_RD_OUT && nxt == S_RD_GAP)
        PIX_IDX <= PIX_IDX + IDX_W'(1);
      if (state == S_RD_DRIVE && nxt == S_RD_OUT)
        PIX_DATA <= CNT_W'(gray_dec(32'(DATA_IN[PIX_IDX*CNT_W +: CNT_W])));
    end
  end

endmodule
